// File: rtl/io_timer_ctrl.sv
// Memory-mapped I/O ports, down-counting interval timer and edge-detected external IRQs
// on the CPU external bus. It drives the 8-bit interrupt request vector.
//
// state  | meaning
// T_IDLE | timer stopped (CTRL.EN = 0), COUNT frozen
// T_RUN  | timer counting down towards 0, expiry at terminal count
module io_timer_ctrl #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        oe,
  input  logic [15:0] Direcciones,
  inout  wire  [15:0] Datos,
  input  logic [15:0] in_port0,
  input  logic [15:0] in_port1,
  output logic [15:0] out_port0,
  output logic [15:0] out_port1,
  input  logic [6:0]  ext_irq,
  output logic [7:0]  intr
);

  typedef enum logic {T_IDLE = 1'b0, T_RUN = 1'b1} tmr_state_e;

  localparam logic [3:0] A_OUT0   = 4'd0;
  localparam logic [3:0] A_OUT1   = 4'd1;
  localparam logic [3:0] A_IN0    = 4'd2;
  localparam logic [3:0] A_IN1    = 4'd3;
  localparam logic [3:0] A_RELOAD = 4'd4;
  localparam logic [3:0] A_CTRL   = 4'd5;
  localparam logic [3:0] A_COUNT  = 4'd6;
  localparam logic [3:0] A_STATUS = 4'd7;

  tmr_state_e  state_q, state_d;
  logic [15:0] out0_q, out1_q, reload_q;
  logic [15:0] count_q, count_d;
  logic        auto_q, auto_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  intr_q, intr_d;
  logic [15:0] in0_s1_q, in0_s2_q, in1_s1_q, in1_s2_q;
  logic [6:0]  irq_s1_q, irq_s2_q, irq_prev_q;

  logic        in_win, wr_en, rd_en, expire;
  logic [3:0]  off;
  logic [15:0] wdata, rd_data;

  assign in_win = (Direcciones[15:4] == BASE_ADDR[15:4]);
  assign wr_en  = oe & in_win;
  assign rd_en  = ~oe & in_win;
  assign off    = Direcciones[3:0];
  assign wdata  = Datos;
  assign expire = (state_q == T_RUN) && (count_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    auto_d   = auto_q;
    intr_d   = {irq_s2_q & ~irq_prev_q, expire};

    case (state_q)
      T_RUN: begin
        if (count_q != 16'd0) begin
          count_d = count_q - 16'd1;
        end else if (auto_q) begin
          count_d = reload_q;
        end else begin
          state_d = T_IDLE;
        end
      end
      default: state_d = T_IDLE;
    endcase

    // A CTRL write overrides whatever the expiry logic decided this edge.
    if (wr_en && (off == A_CTRL)) begin
      auto_d  = wdata[1];
      state_d = wdata[0] ? T_RUN : T_IDLE;
      count_d = wdata[0] ? reload_q : count_q;
    end

    status_d = status_q;
    if (wr_en && (off == A_STATUS)) begin
      status_d = status_q & ~wdata[7:0];
    end
    status_d = status_d | intr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= T_IDLE;
      count_q    <= '0;
      auto_q     <= 1'b0;
      status_q   <= '0;
      intr_q     <= '0;
      out0_q     <= '0;
      out1_q     <= '0;
      reload_q   <= '0;
      in0_s1_q   <= '0;
      in0_s2_q   <= '0;
      in1_s1_q   <= '0;
      in1_s2_q   <= '0;
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      auto_q     <= auto_d;
      status_q   <= status_d;
      intr_q     <= intr_d;
      in0_s1_q   <= in_port0;
      in0_s2_q   <= in0_s1_q;
      in1_s1_q   <= in_port1;
      in1_s2_q   <= in1_s1_q;
      irq_s1_q   <= ext_irq;
      irq_s2_q   <= irq_s1_q;
      irq_prev_q <= irq_s2_q;
      if (wr_en && (off == A_OUT0))   out0_q   <= wdata;
      if (wr_en && (off == A_OUT1))   out1_q   <= wdata;
      if (wr_en && (off == A_RELOAD)) reload_q <= wdata;
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      A_OUT0:   rd_data = out0_q;
      A_OUT1:   rd_data = out1_q;
      A_IN0:    rd_data = in0_s2_q;
      A_IN1:    rd_data = in1_s2_q;
      A_RELOAD: rd_data = reload_q;
      A_CTRL:   rd_data = {14'd0, auto_q, (state_q == T_RUN)};
      A_COUNT:  rd_data = count_q;
      A_STATUS: rd_data = {8'd0, status_q};
      default:  rd_data = '0;
    endcase
  end

  // Released whenever the CPU owns the bus or the address is outside the window.
  assign Datos     = rd_en ? rd_data : 16'hzzzz;
  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign intr      = intr_q;

endmodule
